sequence_serializer: RTL and testbench
======================================

SEQUENCE_SERIALIZER -- requirements
Module: sequence_serializer

Interface
REQ-001 Parameter WORD_SIZE, default 8: width of sequence word and number of bits shifted per frame.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WORD_SIZE-1 first, 0 shifts bit 0 first.
REQ-003 Port slow_clock  input  1  block clock; all state updates on rising edge.
REQ-004 Port reset  input  1  reset, asynchronous, active-high.
REQ-005 Port enable  input  1  permits start of new frames; sampled only in IDLE.
REQ-006 Port force  input  1  requests a frame even if word unchanged; sampled only in IDLE.
REQ-007 Port sequence  input  WORD_SIZE  word from upstream sequencer; produced in another clock domain.
REQ-008 Port ser_data  output  1  serial data to external shift register.
REQ-009 Port ser_clk  output  1  shift clock; external device shifts on its rising edge.
REQ-010 Port ser_latch  output  1  one-cycle storage-register latch strobe.
REQ-011 Port busy  output  1  high from SETUP of bit 0 through LATCH.
REQ-012 Port frame_done  output  1  one-cycle pulse, coincident with ser_latch.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 sequence SHALL be sampled into seq_s every cycle; a word is "stable" when sequence equals seq_s.
REQ-015 FSM states SHALL be IDLE, SETUP, CLK_HI, LATCH.
REQ-016 IDLE -> SETUP when enable=1 and stable and (force=1 or seq_s != last_sent or first_pending=1); shadow and last_sent load seq_s, bit_cnt clears, first_pending clears.
REQ-017 IDLE with any start condition false SHALL hold IDLE; outputs ser_clk, ser_latch, busy, frame_done = 0; ser_data holds.
REQ-018 SETUP: ser_data = current shadow bit (per MSB_FIRST), ser_clk = 0, busy = 1; next state CLK_HI.
REQ-019 CLK_HI: ser_clk = 1, ser_data unchanged; if bit_cnt = WORD_SIZE-1 next LATCH, else bit_cnt increments and next SETUP.
REQ-020 LATCH: ser_latch = 1, frame_done = 1, ser_clk = 0, busy = 1; next IDLE unconditionally.
REQ-021 Frame length SHALL be exactly 2*WORD_SIZE+1 cycles from first SETUP to end of LATCH; minimum one IDLE cycle between frames.
REQ-022 Changes on sequence during a frame SHALL NOT alter shifted bits; the new word is considered at next IDLE.
REQ-023 enable or force changes during a frame SHALL NOT abort or extend the frame.
REQ-024 bit_cnt width SHALL be clog2(WORD_SIZE), minimum 1; no wrap occurs since LATCH exits at WORD_SIZE-1.
REQ-025 force with unchanged word SHALL retransmit last_sent value; force with enable=0 SHALL be ignored.
REQ-026 An unstable sequence (differs from seq_s) SHALL delay start until stable; no frame carries a mixed word.

Reset
REQ-027 reset SHALL immediately force state IDLE, all outputs 0, bit_cnt 0, shadow/last_sent/seq_s 0, first_pending 1.
REQ-028 reset mid-frame SHALL abandon the frame with no ser_latch pulse; first enabled stable IDLE cycle after release starts a frame.

Structure
REQ-029 FSM state encoding and state-name constants SHALL live in shared package sequencer_pkg.
REQ-030 Single module, no sub-modules; bit selection as index mux on bit_cnt.

Verification
REQ-031 Reset release, enable=1, sequence=8'hA5 stable -> one frame, ser_data sampled at ser_clk rises = 1,0,1,0,0,1,0,1, ser_latch after 17 cycles.
REQ-032 sequence held 8'hA5 after first frame, force=0 -> no second frame; pulse force=1 one cycle -> identical 8'hA5 frame.
REQ-033 sequence changes 8'h3C -> 8'hC3 during SETUP of bit 3 -> current frame shifts 8'h3C; next frame shifts 8'hC3.
REQ-034 MSB_FIRST=0, sequence=8'h01 -> first shifted bit 1, remaining seven 0.
REQ-035 reset asserted during CLK_HI of bit 5 -> all outputs 0 same cycle, no frame_done; after release with 8'h5A stable, full 8'h5A frame.
REQ-036 sequence toggling every cycle between 8'h00 and 8'hFF with enable=1 -> no frame starts; stop toggling at 8'hFF -> frame 8'hFF two cycles later.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared definitions for the sequence serializer: FSM state encoding and
// a sizing helper for the bit counter.
package sequencer_pkg;

    // Serializer FSM states; one SETUP/CLK_HI pair per shifted bit.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_CLK_HI = 2'd2,
        ST_LATCH  = 2'd3
    } ser_state_e;

    // Bit counter width: enough to index a word, never narrower than one bit.
    function automatic int cnt_width(input int word_size);
        return (word_size > 1) ? $clog2(word_size) : 1;
    endfunction

endpackage

// File: rtl/sequence_serializer.sv
// Sequence serializer: captures a word from an upstream sequencer running in
// another clock domain and shifts it out to an external shift register as a
// data/shift-clock/latch triple. A word is only sent once it has been seen
// unchanged for a cycle, and only when it differs from the last word sent
// (or a forced retransmission / the first frame after reset is pending).
// force_frame is the forced-retransmission request; sequence_word is the
// upstream word.
module sequence_serializer
    import sequencer_pkg::*;
#(
    parameter int WORD_SIZE = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                 slow_clock,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 force_frame,
    input  logic [WORD_SIZE-1:0] sequence_word,
    output logic                 ser_data,
    output logic                 ser_clk,
    output logic                 ser_latch,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int               CNT_W    = cnt_width(WORD_SIZE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORD_SIZE - 1);
    localparam logic [CNT_W-1:0] ZERO_CNT = {CNT_W{1'b0}};

    ser_state_e           state_r;
    logic [WORD_SIZE-1:0] seq_s;
    logic [WORD_SIZE-1:0] shadow_r;
    logic [WORD_SIZE-1:0] last_sent_r;
    logic [CNT_W-1:0]     bit_cnt_r;
    logic                 first_pending_r;

    logic                 stable_s;
    logic                 start_s;
    logic [CNT_W-1:0]     next_cnt_s;

    // Map the frame position onto the word bit to shift (shift order select).
    function automatic logic [CNT_W-1:0] bit_index(input logic [CNT_W-1:0] cnt);
        if (MSB_FIRST) begin
            bit_index = LAST_CNT - cnt;
        end else begin
            bit_index = cnt;
        end
    endfunction

    // The word is trusted only when it matches last cycle's sample, so a
    // word still settling from the other domain never starts a frame.
    assign stable_s   = (sequence_word == seq_s);
    assign start_s    = enable && stable_s &&
                        (force_frame || (seq_s != last_sent_r) || first_pending_r);
    assign next_cnt_s = bit_cnt_r + CNT_W'(1);

    // Sample the upstream word every cycle for the stability comparison.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            seq_s <= {WORD_SIZE{1'b0}};
        end else begin
            seq_s <= sequence_word;
        end
    end

    // Frame FSM; outputs are registered alongside the state they belong to.
    always_ff @(posedge slow_clock or posedge reset) begin
        if (reset) begin
            state_r         <= ST_IDLE;
            shadow_r        <= {WORD_SIZE{1'b0}};
            last_sent_r     <= {WORD_SIZE{1'b0}};
            bit_cnt_r       <= ZERO_CNT;
            first_pending_r <= 1'b1;
            ser_data        <= 1'b0;
            ser_clk         <= 1'b0;
            ser_latch       <= 1'b0;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    ser_clk    <= 1'b0;
                    ser_latch  <= 1'b0;
                    frame_done <= 1'b0;
                    if (start_s) begin
                        state_r         <= ST_SETUP;
                        shadow_r        <= seq_s;
                        last_sent_r     <= seq_s;
                        bit_cnt_r       <= ZERO_CNT;
                        first_pending_r <= 1'b0;
                        // shadow_r is loaded this same edge, so take bit 0 from seq_s.
                        ser_data        <= seq_s[bit_index(ZERO_CNT)];
                        busy            <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    state_r <= ST_CLK_HI;
                    ser_clk <= 1'b1;
                    busy    <= 1'b1;
                end
                ST_CLK_HI: begin
                    ser_clk <= 1'b0;
                    busy    <= 1'b1;
                    if (bit_cnt_r == LAST_CNT) begin
                        state_r    <= ST_LATCH;
                        ser_latch  <= 1'b1;
                        frame_done <= 1'b1;
                    end else begin
                        state_r   <= ST_SETUP;
                        bit_cnt_r <= next_cnt_s;
                        ser_data  <= shadow_r[bit_index(next_cnt_s)];
                    end
                end
                ST_LATCH: begin
                    state_r    <= ST_IDLE;
                    ser_clk    <= 1'b0;
                    ser_latch  <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    ser_clk    <= 1'b0;
                    ser_latch  <= 1'b0;
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_serializer.sv
// Directed bench for sequence_serializer: an MSB-first and an LSB-first
// instance, frames captured at the falling edge and compared with
// hand-computed words, lengths and strobe positions.
module tb_sequence_serializer;

    logic       slow_clock = 1'b0;
    logic       reset;
    logic       enable;
    logic       force_frame;
    logic [7:0] sequence_word;
    logic       enable_b;
    logic       force_b;
    logic [7:0] seq_b;

    logic ser_data, ser_clk, ser_latch, busy, frame_done;
    logic ser_data_b, ser_clk_b, ser_latch_b, busy_b, frame_done_b;

    logic       sel_b;
    logic [4:0] mon;

    int err_cnt = 0;
    int chk_cnt = 0;

    sequence_serializer #(.WORD_SIZE(8), .MSB_FIRST(1'b1)) dut_msb (
        .slow_clock    (slow_clock),
        .reset         (reset),
        .enable        (enable),
        .force_frame   (force_frame),
        .sequence_word (sequence_word),
        .ser_data      (ser_data),
        .ser_clk       (ser_clk),
        .ser_latch     (ser_latch),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    sequence_serializer #(.WORD_SIZE(8), .MSB_FIRST(1'b0)) dut_lsb (
        .slow_clock    (slow_clock),
        .reset         (reset),
        .enable        (enable_b),
        .force_frame   (force_b),
        .sequence_word (seq_b),
        .ser_data      (ser_data_b),
        .ser_clk       (ser_clk_b),
        .ser_latch     (ser_latch_b),
        .busy          (busy_b),
        .frame_done    (frame_done_b)
    );

    always #5 slow_clock = ~slow_clock;

    // Monitored output bundle: {ser_data, ser_clk, ser_latch, busy, frame_done}.
    assign mon = sel_b ? {ser_data_b, ser_clk_b, ser_latch_b, busy_b, frame_done_b}
                       : {ser_data, ser_clk, ser_latch, busy, frame_done};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a frame on the monitored instance and record it.
    // chg_at / rst_at name the busy-cycle at which to change the word or
    // assert reset; 0 means never.
    task automatic capture(input int wait_max, input int chg_at, input logic [7:0] chg_val,
                           input int rst_at,
                           output logic started, output int waited, output logic [7:0] word,
                           output int len, output int latch_at, output int done_cnt);
        logic prev_clk;
        started  = 1'b0;
        waited   = 0;
        word     = 8'h00;
        len      = 0;
        latch_at = 0;
        done_cnt = 0;
        prev_clk = 1'b0;
        while (!mon[1] && waited < wait_max) begin
            @(negedge slow_clock);
            waited++;
        end
        started = mon[1];
        while (mon[1] && len < 40) begin
            len++;
            if (mon[3] && !prev_clk) word = {word[6:0], mon[4]};
            if (mon[2]) latch_at = len;
            if (mon[0]) done_cnt++;
            prev_clk = mon[3];
            if (len == chg_at) begin
                if (sel_b) seq_b = chg_val;
                else sequence_word = chg_val;
            end
            if (len == rst_at) begin
                reset = 1'b1;
                #1;
                check_val("rst_mid_outs", {27'd0, mon}, 32'd0);
            end
            @(negedge slow_clock);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       st;
        int         wt;
        logic [7:0] wd;
        int         ln;
        int         la;
        int         dc;
        int         busy_seen;

        reset         = 1'b1;
        enable        = 1'b0;
        force_frame   = 1'b0;
        sequence_word = 8'h00;
        enable_b      = 1'b0;
        force_b       = 1'b0;
        seq_b         = 8'h00;
        sel_b         = 1'b0;
        repeat (3) @(negedge slow_clock);
        check_val("reset_outs", {27'd0, mon}, 32'd0);
        check_val("reset_outs_b", {27'd0, ser_data_b, ser_clk_b, ser_latch_b, busy_b, frame_done_b}, 32'd0);

        // First frame after reset release with a stable A5.
        sequence_word = 8'hA5;
        enable        = 1'b1;
        reset         = 1'b0;
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("a5_start", {31'd0, st}, 32'd1);
        check_val("a5_wait", wt, 32'd2);
        check_val("a5_word", {24'd0, wd}, 32'hA5);
        check_val("a5_len", ln, 32'd17);
        check_val("a5_latch_pos", la, 32'd17);
        check_val("a5_done_pulses", dc, 32'd1);
        check_val("idle_outs", {27'd0, mon}, 32'h10);

        // Unchanged word: no repeat until forced.
        capture(20, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("no_repeat", {31'd0, st}, 32'd0);
        force_frame = 1'b1;
        @(negedge slow_clock);
        force_frame = 1'b0;
        capture(5, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("force_word", {24'd0, wd}, 32'hA5);
        check_val("force_len", ln, 32'd17);

        // Word changes during SETUP of bit 3: current frame keeps 3C.
        sequence_word = 8'h3C;
        capture(10, 7, 8'hC3, 0, st, wt, wd, ln, la, dc);
        check_val("mid_change_word", {24'd0, wd}, 32'h3C);
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("next_frame_gap", wt, 32'd1);
        check_val("next_frame_word", {24'd0, wd}, 32'hC3);

        // force while disabled is ignored.
        enable      = 1'b0;
        force_frame = 1'b1;
        capture(8, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("force_no_enable", {31'd0, st}, 32'd0);
        force_frame = 1'b0;
        enable      = 1'b1;

        // Reset during CLK_HI of bit 5 abandons the frame.
        sequence_word = 8'h0F;
        capture(10, 0, 8'h00, 12, st, wt, wd, ln, la, dc);
        check_val("rst_started", {31'd0, st}, 32'd1);
        check_val("rst_no_latch", la, 32'd0);
        check_val("rst_no_done", dc, 32'd0);
        sequence_word = 8'h5A;
        repeat (2) @(negedge slow_clock);
        reset = 1'b0;
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("post_rst_word", {24'd0, wd}, 32'h5A);
        check_val("post_rst_len", ln, 32'd17);
        check_val("post_rst_done", dc, 32'd1);

        // Toggling word never settles, so no frame starts.
        busy_seen = 0;
        for (int i = 0; i < 9; i++) begin
            sequence_word = ((i % 2) == 1) ? 8'hFF : 8'h00;
            @(negedge slow_clock);
            if (busy) busy_seen++;
        end
        check_val("toggle_no_start", busy_seen, 32'd0);
        sequence_word = 8'hFF;
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("settle_wait", wt, 32'd2);
        check_val("settle_word", {24'd0, wd}, 32'hFF);

        // LSB-first instance.
        sel_b    = 1'b1;
        seq_b    = 8'h01;
        enable_b = 1'b1;
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("lsb_01_bits", {24'd0, wd}, 32'h80);
        check_val("lsb_01_len", ln, 32'd17);
        seq_b = 8'h0B;
        capture(10, 0, 8'h00, 0, st, wt, wd, ln, la, dc);
        check_val("lsb_0b_bits", {24'd0, wd}, 32'hD0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
